// File: rtl/trap_vector_unit.sv
// trap_vector_unit: next-PC and trap-vector generator for the fetch stage.
//
// Drives the registered fetch PC from the boot address, sequential increments, branch
// redirects, latched interrupts (optionally vectored by cause), interrupt return and an
// optional debug entry/return path.
//
// Optional feature macro: DPROC_DEBUG_EN
//   defined   -> DEBUG state, dpc register, debug_req_i / dret_i honoured
//   undefined -> no DEBUG state, debug inputs ignored, debug_mode_o tied to 0
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   stall_i              fetch not ready; freezes all PC state except pending interrupts
//   branch_i, branch_target_i   redirect request and target
//   irq_i, irq_en_i      level interrupt requests, global enable
//   mret_i               return from interrupt handler
//   debug_req_i, dret_i  debug halt request, return from debug
//   pc_o, pc_valid_o     registered fetch PC and its valid flag
//   irq_ack_o, irq_cause_o      one-cycle take pulse and taken channel index
//   epc_o                saved interrupt return PC
//   in_handler_o         interrupt handler active (nesting masked)
//   debug_mode_o         in DEBUG state
module trap_vector_unit #(
  parameter logic [31:0] BOOT_ADDRESS      = 32'h0000_0000,
  parameter logic [31:0] INTERRUPT_ADDRESS = 32'hFF00_000A,
  parameter logic [31:0] DEBUG_ADDRESS     = 32'hFF00_000B,
  parameter int unsigned NB_IRQ            = 4,
  parameter bit          VECTORED          = 1'b0,
  localparam int unsigned CW = (NB_IRQ > 1) ? $clog2(NB_IRQ) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [31:0]       branch_target_i,
  input  logic [NB_IRQ-1:0] irq_i,
  input  logic              irq_en_i,
  input  logic              mret_i,
  input  logic              debug_req_i,
  input  logic              dret_i,
  output logic [31:0]       pc_o,
  output logic              pc_valid_o,
  output logic              irq_ack_o,
  output logic [CW-1:0]     irq_cause_o,
  output logic [31:0]       epc_o,
  output logic              in_handler_o,
  output logic              debug_mode_o
);

`ifdef DPROC_DEBUG_EN
  typedef enum logic [1:0] {StReset, StRun, StDebug} state_e;
`else
  typedef enum logic [1:0] {StReset, StRun} state_e;
`endif

  state_e            r_state, w_state_d;
  logic [31:0]       r_pc, w_pc_d;
  logic [31:0]       r_epc, w_epc_d;
  logic [NB_IRQ-1:0] r_pending, w_pending_d;
  logic              r_in_handler, w_in_handler_d;
  logic              r_irq_ack, w_irq_ack_d;
  logic [CW-1:0]     r_irq_cause, w_irq_cause_d;
`ifdef DPROC_DEBUG_EN
  logic [31:0]       r_dpc, w_dpc_d;
`else
  logic              w_unused_debug;
  assign w_unused_debug = debug_req_i ^ dret_i;
`endif

  logic [NB_IRQ-1:0] w_eligible;
  logic [CW-1:0]     w_cause;
  logic [31:0]       w_seq_pc;
  logic [31:0]       w_vec_pc;

  assign w_eligible = r_pending & {NB_IRQ{irq_en_i & ~r_in_handler}};

  // Downward scan so the lowest set index is the last assignment and wins.
  always_comb begin
    w_cause = '0;
    for (int i = int'(NB_IRQ) - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_cause = CW'(i);
    end
  end

  assign w_seq_pc = branch_i ? branch_target_i : r_pc + 32'd4;
  assign w_vec_pc = VECTORED ? INTERRUPT_ADDRESS + (32'(w_cause) << 2) : INTERRUPT_ADDRESS;

  always_comb begin
    w_state_d      = r_state;
    w_pc_d         = r_pc;
    w_epc_d        = r_epc;
    w_in_handler_d = r_in_handler;
    w_irq_ack_d    = 1'b0;
    w_irq_cause_d  = r_irq_cause;
    // Requests latch in every state; a same-cycle take clears below (absorbed).
    w_pending_d    = r_pending | irq_i;
`ifdef DPROC_DEBUG_EN
    w_dpc_d        = r_dpc;
`endif
    unique case (r_state)
      StReset: w_state_d = StRun;
      StRun: begin
        if (!stall_i) begin
`ifdef DPROC_DEBUG_EN
          if (debug_req_i) begin
            w_dpc_d   = w_seq_pc;
            w_pc_d    = DEBUG_ADDRESS;
            w_state_d = StDebug;
          end else
`endif
          if (mret_i && r_in_handler) begin
            w_pc_d         = r_epc;
            w_in_handler_d = 1'b0;
          end else if (|w_eligible) begin
            w_epc_d              = w_seq_pc;
            w_pc_d               = w_vec_pc;
            w_in_handler_d       = 1'b1;
            w_pending_d[w_cause] = 1'b0;
            w_irq_ack_d          = 1'b1;
            w_irq_cause_d        = w_cause;
          end else begin
            w_pc_d = w_seq_pc;
          end
        end
      end
`ifdef DPROC_DEBUG_EN
      StDebug: begin
        if (!stall_i) begin
          if (dret_i) begin
            w_pc_d    = r_dpc;
            w_state_d = StRun;
          end else begin
            w_pc_d = w_seq_pc;
          end
        end
      end
`endif
      default: w_state_d = StReset;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= StReset;
      r_pc         <= BOOT_ADDRESS;
      r_epc        <= '0;
      r_pending    <= '0;
      r_in_handler <= 1'b0;
      r_irq_ack    <= 1'b0;
      r_irq_cause  <= '0;
`ifdef DPROC_DEBUG_EN
      r_dpc        <= '0;
`endif
    end else begin
      r_state      <= w_state_d;
      r_pc         <= w_pc_d;
      r_epc        <= w_epc_d;
      r_pending    <= w_pending_d;
      r_in_handler <= w_in_handler_d;
      r_irq_ack    <= w_irq_ack_d;
      r_irq_cause  <= w_irq_cause_d;
`ifdef DPROC_DEBUG_EN
      r_dpc        <= w_dpc_d;
`endif
    end
  end

  assign pc_o         = r_pc;
  assign pc_valid_o   = (r_state != StReset);
  assign irq_ack_o    = r_irq_ack;
  assign irq_cause_o  = r_irq_cause;
  assign epc_o        = r_epc;
  assign in_handler_o = r_in_handler;
`ifdef DPROC_DEBUG_EN
  assign debug_mode_o = (r_state == StDebug);
`else
  assign debug_mode_o = 1'b0;
`endif

endmodule

// File: tb/tb_trap_vector_unit.sv
// Directed testbench for trap_vector_unit (NB_IRQ=4, VECTORED=1).
module tb_trap_vector_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_i, branch_i, irq_en_i, mret_i, debug_req_i, dret_i;
  logic [31:0] branch_target_i;
  logic [3:0]  irq_i;
  logic [31:0] pc_o, epc_o;
  logic        pc_valid_o, irq_ack_o, in_handler_o, debug_mode_o;
  logic [1:0]  irq_cause_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  trap_vector_unit #(
    .BOOT_ADDRESS     (32'h0000_0000),
    .INTERRUPT_ADDRESS(32'hFF00_000A),
    .DEBUG_ADDRESS    (32'hFF00_000B),
    .NB_IRQ           (4),
    .VECTORED         (1'b1)
  ) u_dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .stall_i        (stall_i),
    .branch_i       (branch_i),
    .branch_target_i(branch_target_i),
    .irq_i          (irq_i),
    .irq_en_i       (irq_en_i),
    .mret_i         (mret_i),
    .debug_req_i    (debug_req_i),
    .dret_i         (dret_i),
    .pc_o           (pc_o),
    .pc_valid_o     (pc_valid_o),
    .irq_ack_o      (irq_ack_o),
    .irq_cause_o    (irq_cause_o),
    .epc_o          (epc_o),
    .in_handler_o   (in_handler_o),
    .debug_mode_o   (debug_mode_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance past one rising edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; stall_i = 1'b0; branch_i = 1'b0; branch_target_i = '0;
    irq_i = '0; irq_en_i = 1'b0; mret_i = 1'b0; debug_req_i = 1'b0; dret_i = 1'b0;
    #2;
    check("rst_pc", pc_o, 32'h0);
    check("rst_valid", 32'(pc_valid_o), 32'h0);
    check("rst_ack", 32'(irq_ack_o), 32'h0);
    check("rst_inh", 32'(in_handler_o), 32'h0);
    check("rst_epc", epc_o, 32'h0);
    check("rst_dbg", 32'(debug_mode_o), 32'h0);
    step();
    rst_ni = 1'b1;

    // Boot and sequential fetch
    step();
    check("boot_valid", 32'(pc_valid_o), 32'h1);
    check("boot_pc", pc_o, 32'h0);
    step(); check("seq_4", pc_o, 32'h4);
    step(); check("seq_8", pc_o, 32'h8);
    step(); check("seq_c", pc_o, 32'hC);

    // Stalled branch is held off until release
    stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step(); check("stall_hold", pc_o, 32'hC);
    end
    stall_i = 1'b0;
    step(); check("branch_rel", pc_o, 32'h100);

    // Vectored interrupts, tail-chain and absorb
    branch_target_i = 32'h1C;
    step(); check("br_1c", pc_o, 32'h1C);
    branch_i = 1'b0; irq_i = 4'b0110; irq_en_i = 1'b1;
    step(); check("pend_pc", pc_o, 32'h20);
    check("pend_noack", 32'(irq_ack_o), 32'h0);
    step();
    check("irq1_ack", 32'(irq_ack_o), 32'h1);
    check("irq1_cause", 32'(irq_cause_o), 32'h1);
    check("irq1_pc", pc_o, 32'hFF00_000E);
    check("irq1_epc", epc_o, 32'h24);
    check("irq1_inh", 32'(in_handler_o), 32'h1);
    irq_i = '0;
    step();
    check("nest_noack", 32'(irq_ack_o), 32'h0);
    check("nest_pc", pc_o, 32'hFF00_0012);
    mret_i = 1'b1;
    step();
    check("mret1_pc", pc_o, 32'h24);
    check("mret1_inh", 32'(in_handler_o), 32'h0);
    mret_i = 1'b0;
    step();
    check("irq2_ack", 32'(irq_ack_o), 32'h1);
    check("irq2_cause", 32'(irq_cause_o), 32'h2);
    check("irq2_pc", pc_o, 32'hFF00_0012);
    check("irq2_epc", epc_o, 32'h28);
    mret_i = 1'b1;
    step(); check("mret2_pc", pc_o, 32'h28);
    mret_i = 1'b0;
    step();
    check("absorb_noack", 32'(irq_ack_o), 32'h0);
    check("absorb_pc", pc_o, 32'h2C);

    // Masked interrupt stays pending
    irq_en_i = 1'b0; irq_i = 4'b0001;
    step(); check("mask_pc0", pc_o, 32'h30);
    irq_i = '0;
    step(); check("mask_noack0", 32'(irq_ack_o), 32'h0);
    step(); check("mask_noack1", 32'(irq_ack_o), 32'h0);
    check("mask_pc1", pc_o, 32'h38);
    irq_en_i = 1'b1;
    step();
    check("sticky_ack", 32'(irq_ack_o), 32'h1);
    check("sticky_cause", 32'(irq_cause_o), 32'h0);
    check("sticky_pc", pc_o, 32'hFF00_000A);
    check("sticky_epc", epc_o, 32'h3C);
    mret_i = 1'b1;
    step(); check("mret3_pc", pc_o, 32'h3C);
    mret_i = 1'b0;
    step(); check("pc_40", pc_o, 32'h40);

`ifdef DPROC_DEBUG_EN
    debug_req_i = 1'b1; irq_i = 4'b0001;
    step();
    check("dbg_pc", pc_o, 32'hFF00_000B);
    check("dbg_mode", 32'(debug_mode_o), 32'h1);
    check("dbg_noack", 32'(irq_ack_o), 32'h0);
    debug_req_i = 1'b0; irq_i = '0;
    step();
    check("dbg_seq", pc_o, 32'hFF00_000F);
    check("dbg_noack2", 32'(irq_ack_o), 32'h0);
    dret_i = 1'b1;
    step();
    check("dret_pc", pc_o, 32'h44);
    check("dret_mode", 32'(debug_mode_o), 32'h0);
    dret_i = 1'b0;
    step();
    check("post_dbg_ack", 32'(irq_ack_o), 32'h1);
    check("post_dbg_pc", pc_o, 32'hFF00_000A);
    check("post_dbg_epc", epc_o, 32'h48);
    mret_i = 1'b1;
    step(); check("mret4_pc", pc_o, 32'h48);
    mret_i = 1'b0;
`else
    debug_req_i = 1'b1;
    step();
    check("nodbg_pc", pc_o, 32'h44);
    check("nodbg_mode", 32'(debug_mode_o), 32'h0);
    debug_req_i = 1'b0;
`endif

    // PC wrap
    branch_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    step(); check("wrap_top", pc_o, 32'hFFFF_FFFC);
    branch_i = 1'b0;
    step(); check("wrap_zero", pc_o, 32'h0);

    // Asynchronous reset while in a handler
    irq_i = 4'b0001;
    step();
    irq_i = '0;
    step();
    check("pre_rst_inh", 32'(in_handler_o), 32'h1);
    check("pre_rst_pc", pc_o, 32'hFF00_000A);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_pc", pc_o, 32'h0);
    check("arst_valid", 32'(pc_valid_o), 32'h0);
    check("arst_inh", 32'(in_handler_o), 32'h0);
    check("arst_ack", 32'(irq_ack_o), 32'h0);
    check("arst_epc", epc_o, 32'h0);
    check("arst_dbg", 32'(debug_mode_o), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_vector_unit.md
# trap_vector_unit

Parametrised next-PC and trap-vector generator for the ECAP5-DPROC fetch stage. It takes the fixed boot, interrupt and debug addresses and turns them into a sequenced program-counter source with:
- latched multi-channel interrupts, optionally vectored by cause;
- an interrupt-return path;
- an optional debug-mode entry/return path.

It sits between the hazard/branch logic and instruction fetch, and drives the registered fetch PC every non-stalled cycle.

## Interface
Parameters:
- BOOT_ADDRESS, 32'h00000000, PC loaded at reset.
- INTERRUPT_ADDRESS, 32'hFF00000A, interrupt vector base.
- DEBUG_ADDRESS, 32'hFF00000B, debug entry PC.
- NB_IRQ, 4, number of interrupt channels (1..16).
- VECTORED, 0, 1 = target is INTERRUPT_ADDRESS + 4*cause; 0 = all interrupts go to INTERRUPT_ADDRESS.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- stall_i  in  1  fetch not ready; holds all PC state.
- branch_i  in  1  redirect request, sampled only when stall_i=0.
- branch_target_i  in  32  redirect target.
- irq_i  in  NB_IRQ  level interrupt requests.
- irq_en_i  in  1  global interrupt enable.
- mret_i  in  1  return from interrupt handler.
- debug_req_i  in  1  debug halt request.
- dret_i  in  1  return from debug.
- pc_o  out  32  registered fetch PC.
- pc_valid_o  out  1  pc_o is valid.
- irq_ack_o  out  1  one-cycle pulse when an interrupt is taken.
- irq_cause_o  out  $clog2(NB_IRQ) (min 1)  index of the channel taken; valid with irq_ack_o.
- epc_o  out  32  saved return PC for interrupts.
- in_handler_o  out  1  interrupt handler active (nesting masked).
- debug_mode_o  out  1  in DEBUG state.

## Operation
States:
- RESET: entered on reset. Leaves for RUN after one clock with rst_ni high.
- RUN: normal sequencing.
- DEBUG: debug mode.

Pending interrupts:
- pending[i] sets when irq_i[i]=1.
- pending[i] is sticky until channel i is taken.
- Setting happens in every state, including during stall.

Interrupt eligibility:
- eligible = pending & {NB_IRQ{irq_en_i & ~in_handler}}.
- Lowest set index wins.

Next-PC priority in RUN when stall_i=0, highest first:
1. debug_req_i: save dpc = current next PC; pc_o = DEBUG_ADDRESS; go to DEBUG.
2. mret_i with in_handler=1: pc_o = epc; clear in_handler.
3. Eligible interrupt k:
   - epc = branch_target_i if branch_i, else pc_o+4;
   - pc_o = vector target; set in_handler; clear pending[k];
   - irq_ack_o=1 and irq_cause_o=k for that cycle.
4. branch_i: pc_o = branch_target_i.
5. Otherwise: pc_o = pc_o+4.

Other rules:
- mret_i with in_handler=0 is ignored; treat as rule 4/5.
- DEBUG state: pc_o holds DEBUG_ADDRESS plus sequential increments (+4 when not stalled) and honours branch_i. Interrupts stay pending, not taken.
- dret_i (stall_i=0) in DEBUG: pc_o = dpc, go to RUN.
- All PC arithmetic is modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.
- Vectored target is computed in 32 bits with wrap.

## Timing
Reset values:
- pc_o = BOOT_ADDRESS, pc_valid_o = 0.
- irq_ack_o, in_handler_o and debug_mode_o = 0.
- epc_o, dpc and pending = 0.

Latency:
- First rising edge after rst_ni deasserts: pc_valid_o = 1, pc_o = BOOT_ADDRESS.
- Every decision is registered: inputs sampled at edge N are visible on pc_o after edge N.

Stall:
- stall_i=1 freezes pc_o, epc, dpc, state and in_handler.
- irq_ack_o is 0 during stall.
- Only pending may change.

Simultaneous events:
- debug beats mret, interrupt and branch.
- mret beats a pending interrupt; the interrupt is taken on the next non-stalled cycle (tail-chain).
- irq_i rising in the same cycle it is taken is absorbed: pending cleared.

Reset mid-operation: asynchronous return to reset values, whatever the state or stall.

## Configuration
DPROC_DEBUG_EN:
- Defined: DEBUG state, dpc register, debug_req_i/dret_i behaviour as above.
- Undefined: no DEBUG state or dpc; debug_req_i and dret_i are ignored; debug_mode_o is constant 0.

## Test plan
- Reset then release, no stall:
  - pc_valid_o rises with pc_o = 0x00000000.
  - Next three cycles give 0x4, 0x8, 0xC.
- Branch with stall:
  - stall_i=1 for 3 cycles with branch_i=1, target 0x100 → pc_o is unchanged throughout.
  - On release → pc_o = 0x100.
- Vectored interrupt:
  - VECTORED=1, pc_o=0x20, irq_i=4'b0110, irq_en_i=1 → irq_ack_o pulses with cause 1, pc_o = 0xFF00000E, epc_o = 0x24.
  - mret → pc_o = 0x24.
  - The next cycle takes cause 2, pc_o = 0xFF000012.
- Masking:
  - irq_en_i=0 with irq_i[0] pulsed for one cycle → no ack.
  - Later irq_en_i=1 → taken, proving the sticky pending latch.
- Debug (DPROC_DEBUG_EN defined):
  - debug_req_i at pc_o=0x40 with irq_i[0] high → pc_o = 0xFF00000B, debug_mode_o = 1, no irq_ack_o.
  - dret_i → pc_o = 0x44, then the interrupt is taken.
- Wrap and async reset:
  - branch to 0xFFFFFFFC → next pc_o = 0x0.
  - Assert rst_ni low mid-handler → all outputs return to reset values immediately.
